// File: rtl/pll_rst_seq_pkg.sv
// Shared state encoding and default parameters for the PLL reset sequencer.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Optional lock-loss filter is built in with PLL_RST_SEQ_LOSS_FILTER_EN.
package pll_rst_seq_pkg;

    typedef logic [2:0] pll_seq_state_t;

    localparam pll_seq_state_t ST_RESET_PLL = 3'd0;
    localparam pll_seq_state_t ST_WAIT_LOCK = 3'd1;
    localparam pll_seq_state_t ST_RELEASE   = 3'd2;
    localparam pll_seq_state_t ST_RUN       = 3'd3;
    localparam pll_seq_state_t ST_FAULT     = 3'd4;

    localparam int unsigned DEF_RST_CYCLES          = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_N_DOMAINS           = 3;
    localparam int unsigned DEF_STAGGER_CYCLES      = 8;
    localparam int unsigned DEF_MAX_RETRY           = 3;
    localparam int unsigned DEF_LOSS_FILTER_CYCLES  = 4;

endpackage

// File: rtl/pll_lock_sync.sv
// PLL lock 2-flop synchronizer with lock-loss detect (debounced with PLL_RST_SEQ_LOSS_FILTER_EN).
// Latency: lock_s is 2 cycles behind pll_lock; lock_lost is combinational from lock_s.
// Backpressure: none, free-running.
module pll_lock_sync
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned LOSS_FILTER_CYCLES = DEF_LOSS_FILTER_CYCLES
) (
    input  logic init_clk,
    input  logic reset,
    input  logic pll_lock,
    output logic lock_s,
    output logic lock_lost
);

`ifdef PLL_RST_SEQ_LOSS_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // Unfiltered build is the degenerate one-cycle debounce.
    localparam int unsigned          LOSS_N  = FILTER_EN ? LOSS_FILTER_CYCLES : 1;
    localparam int unsigned          LW      = $clog2(LOSS_N + 1);
    localparam logic [LW-1:0]        LOW_MAX = LW'(LOSS_N - 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;

    always_comb begin
        meta_d    = pll_lock;
        sync_d    = meta_q;
        low_cnt_d = low_cnt_q;
        if (sync_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge init_clk) begin
        if (reset) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            low_cnt_q <= '0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            low_cnt_q <= low_cnt_d;
        end
    end

    assign lock_s    = sync_q;
    assign lock_lost = ~sync_q && (low_cnt_q == LOW_MAX);

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for stable lock, releases domain resets staggered.
// Latency: all outputs registered; lock loss reasserts rst_out 3 cycles after pll_lock falls.
// Backpressure: none; bounded retries end in a sticky fault (PLL_RST_SEQ_LOSS_FILTER_EN adds loss debounce).
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned N_DOMAINS           = DEF_N_DOMAINS,
    parameter int unsigned STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
    parameter int unsigned MAX_RETRY           = DEF_MAX_RETRY,
    parameter int unsigned LOSS_FILTER_CYCLES  = DEF_LOSS_FILTER_CYCLES
) (
    input  logic                               init_clk,
    input  logic                               reset,
    input  logic                               pll_lock,
    output logic                               pll_rst,
    output logic [N_DOMAINS-1:0]               rst_out,
    output logic                               locked,
    output logic                               fault,
    output logic [$clog2(MAX_RETRY+1)-1:0]     fail_cnt
);

    localparam int unsigned FW  = $clog2(MAX_RETRY + 1);
    localparam int unsigned RW  = $clog2(RST_CYCLES + 1);
    localparam int unsigned SW  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TW  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned GW  = $clog2((N_DOMAINS - 1) * STAGGER_CYCLES + 2);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_N  = SW'(LOCK_STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] REL_LAST  = GW'((N_DOMAINS - 1) * STAGGER_CYCLES);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_RETRY);

    pll_seq_state_t         state_q, state_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [N_DOMAINS-1:0]   rst_out_q, rst_out_d;
    logic                   locked_q, locked_d;
    logic                   fault_q, fault_d;
    logic [FW-1:0]          fail_cnt_q, fail_cnt_d;
    logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]          stable_q, stable_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [GW-1:0]          rel_q, rel_d;
    logic                   lock_s;
    logic                   lock_lost;

    pll_lock_sync #(
        .LOSS_FILTER_CYCLES (LOSS_FILTER_CYCLES)
    ) u_lock_sync (
        .init_clk  (init_clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .lock_s    (lock_s),
        .lock_lost (lock_lost)
    );

    always_comb begin
        state_d    = state_q;
        pll_rst_d  = pll_rst_q;
        rst_out_d  = rst_out_q;
        locked_d   = locked_q;
        fault_d    = fault_q;
        fail_cnt_d = fail_cnt_q;
        rst_cnt_d  = '0;
        stable_d   = '0;
        tmo_d      = '0;
        rel_d      = '0;
        case (state_q)
            ST_RESET_PLL: begin
                pll_rst_d = 1'b1;
                rst_out_d = '1;
                locked_d  = 1'b0;
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    rst_cnt_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                tmo_d    = tmo_q + 1'b1;
                stable_d = lock_s ? stable_q + 1'b1 : '0;
                // Stable completion is checked first so it wins a same-cycle tie.
                if (stable_q == STABLE_N) begin
                    state_d      = ST_RELEASE;
                    rst_out_d[0] = 1'b0;
                    stable_d     = '0;
                    tmo_d        = '0;
                end else if (tmo_q == TMO_LAST) begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                    pll_rst_d  = 1'b1;
                    stable_d   = '0;
                    tmo_d      = '0;
                    if (fail_cnt_d == FAIL_MAX) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_RESET_PLL;
                    end
                end
            end
            ST_RELEASE: begin
                rel_d = rel_q + 1'b1;
                for (int i = 1; i < int'(N_DOMAINS); i++) begin
                    if (int'(rel_q) + 1 == i * int'(STAGGER_CYCLES)) begin
                        rst_out_d[i] = 1'b0;
                    end
                end
                if (rel_q == REL_LAST) begin
                    state_d  = ST_RUN;
                    locked_d = 1'b1;
                    rel_d    = '0;
                end
            end
            ST_RUN: begin
                fail_cnt_d = '0;
            end
            ST_FAULT: begin
                pll_rst_d = 1'b1;
                rst_out_d = '1;
                locked_d  = 1'b0;
                fault_d   = 1'b1;
            end
            default: begin
                state_d   = ST_RESET_PLL;
                pll_rst_d = 1'b1;
                rst_out_d = '1;
                locked_d  = 1'b0;
            end
        endcase

        // Loss overrides any release progress; the retry budget is left untouched.
        if ((state_q == ST_RELEASE || state_q == ST_RUN) && lock_lost) begin
            state_d    = ST_RESET_PLL;
            pll_rst_d  = 1'b1;
            rst_out_d  = '1;
            locked_d   = 1'b0;
            fail_cnt_d = fail_cnt_q;
            rel_d      = '0;
        end
    end

    always_ff @(posedge init_clk) begin
        if (reset) begin
            state_q    <= ST_RESET_PLL;
            pll_rst_q  <= 1'b1;
            rst_out_q  <= '1;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
            fail_cnt_q <= '0;
            rst_cnt_q  <= '0;
            stable_q   <= '0;
            tmo_q      <= '0;
            rel_q      <= '0;
        end else begin
            state_q    <= state_d;
            pll_rst_q  <= pll_rst_d;
            rst_out_q  <= rst_out_d;
            locked_q   <= locked_d;
            fault_q    <= fault_d;
            fail_cnt_q <= fail_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            stable_q   <= stable_d;
            tmo_q      <= tmo_d;
            rel_q      <= rel_d;
        end
    end

    assign pll_rst  = pll_rst_q;
    assign rst_out  = rst_out_q;
    assign locked   = locked_q;
    assign fault    = fault_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq; loss timing follows PLL_RST_SEQ_LOSS_FILTER_EN.
// Cycle k is the period ending at edge k; cycle 0 follows the last reset edge.
module tb_pll_rst_seq;

`ifdef PLL_RST_SEQ_LOSS_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LOSS_LAT = FILT ? 6 : 3;

    logic       init_clk;
    logic       reset;
    logic       pll_lock;
    logic       pll_rst;
    logic [2:0] rst_out;
    logic       locked;
    logic       fault;
    logic [1:0] fail_cnt;

    int cyc;
    int n_run;
    int n_fail;

    pll_rst_seq #(
        .RST_CYCLES          (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (64),
        .N_DOMAINS           (3),
        .STAGGER_CYCLES      (2),
        .MAX_RETRY           (3),
        .LOSS_FILTER_CYCLES  (4)
    ) dut (
        .init_clk (init_clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_rst  (pll_rst),
        .rst_out  (rst_out),
        .locked   (locked),
        .fault    (fault),
        .fail_cnt (fail_cnt)
    );

    initial init_clk = 1'b0;
    always #5 init_clk = ~init_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to the negedge inside cycle n; inputs set here are sampled at edge n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge init_clk);
            cyc++;
        end
    endtask

    task automatic start_seq();
        pll_lock = 1'b0;
        reset    = 1'b1;
        @(negedge init_clk);
        @(negedge init_clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        n_run    = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        pll_lock = 1'b0;

        // Clean bring-up, then lock loss in RUN
        start_seq();
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_rst_out", rst_out, 3'b111);
        chk("rst_locked", locked, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        goto(3);  chk("up_pll_rst_c3", pll_rst, 1);
        goto(4);  chk("up_pll_rst_c4", pll_rst, 0);
        goto(10); pll_lock = 1'b1;
        goto(20); chk("up_rst_out_c20", rst_out, 3'b111);
        goto(21); chk("up_rst_out_c21", rst_out, 3'b110);
        goto(22); chk("up_rst_out_c22", rst_out, 3'b110);
        goto(23); chk("up_rst_out_c23", rst_out, 3'b100);
        goto(24); chk("up_rst_out_c24", rst_out, 3'b100);
        goto(25); chk("up_rst_out_c25", rst_out, 3'b000);
                  chk("up_locked_c25", locked, 0);
        goto(26); chk("up_locked_c26", locked, 1);
                  chk("up_fail_cnt", fail_cnt, 0);
        goto(30); pll_lock = 1'b0;
        goto(30 + LOSS_LAT - 1);
        chk("loss_locked_before", locked, 1);
        chk("loss_rst_out_before", rst_out, 3'b000);
        goto(30 + LOSS_LAT);
        chk("loss_locked", locked, 0);
        chk("loss_rst_out", rst_out, 3'b111);
        chk("loss_pll_rst", pll_rst, 1);
        chk("loss_fail_cnt", fail_cnt, 0);
        goto(30 + LOSS_LAT + 3); chk("loss_pll_rst_end", pll_rst, 1);
        goto(30 + LOSS_LAT + 4); chk("loss_pll_rst_low", pll_rst, 0);

        // Glitch in WAIT_LOCK at stable count 5, then a 3-cycle dropout in RUN
        start_seq();
        goto(10); pll_lock = 1'b1;
        goto(15); pll_lock = 1'b0;
        goto(16); pll_lock = 1'b1;
        goto(21); chk("gl_rst_out_c21", rst_out, 3'b111);
        goto(26); chk("gl_rst_out_c26", rst_out, 3'b111);
        goto(27); chk("gl_rst_out_c27", rst_out, 3'b110);
                  chk("gl_fail_cnt", fail_cnt, 0);
        goto(32); chk("gl_locked_c32", locked, 1);
        goto(40); pll_lock = 1'b0;
        goto(43); pll_lock = 1'b1;
                  chk("drop_locked_c43", locked, FILT ? 1 : 0);
                  chk("drop_rst_out_c43", rst_out, FILT ? 3'b000 : 3'b111);
        goto(48); chk("drop_locked_c48", locked, FILT ? 1 : 0);

        // Retries exhausted -> FAULT until reset
        start_seq();
        goto(67);  chk("to_pll_rst_c67", pll_rst, 0);
                   chk("to_fail_c67", fail_cnt, 0);
        goto(68);  chk("to_pll_rst_c68", pll_rst, 1);
                   chk("to_fail_c68", fail_cnt, 1);
        goto(71);  chk("to_pll_rst_c71", pll_rst, 1);
        goto(72);  chk("to_pll_rst_c72", pll_rst, 0);
        goto(136); chk("to_fail_c136", fail_cnt, 2);
                   chk("to_pll_rst_c136", pll_rst, 1);
        goto(203); chk("to_fault_c203", fault, 0);
        goto(204); chk("to_fault_c204", fault, 1);
                   chk("to_fail_c204", fail_cnt, 3);
                   chk("to_pll_rst_c204", pll_rst, 1);
                   chk("to_rst_out_c204", rst_out, 3'b111);
        goto(300); chk("to_fault_hold", fault, 1);
                   chk("to_pll_rst_hold", pll_rst, 1);
        reset = 1'b1;
        goto(301); chk("to_reset_fault", fault, 0);
                   chk("to_reset_fail", fail_cnt, 0);

        // One timeout, then lock: fail_cnt clears once in RUN
        start_seq();
        goto(68); chk("rt_fail_c68", fail_cnt, 1);
        goto(70); pll_lock = 1'b1;
        goto(80); chk("rt_rst_out_c80", rst_out, 3'b111);
        goto(81); chk("rt_rst_out_c81", rst_out, 3'b110);
        goto(86); chk("rt_locked_c86", locked, 1);
                  chk("rt_fail_c86", fail_cnt, 1);
        goto(87); chk("rt_fail_c87", fail_cnt, 0);

        // Reset mid-RELEASE, then full resequence with lock held high
        start_seq();
        goto(10); pll_lock = 1'b1;
        goto(21); chk("mr_rst_out_c21", rst_out, 3'b110);
        goto(22); reset = 1'b1;
        goto(23); chk("mr_rst_out", rst_out, 3'b111);
                  chk("mr_pll_rst", pll_rst, 1);
                  chk("mr_locked", locked, 0);
        reset = 1'b0;
        cyc   = 0;
        goto(3);  chk("mr_pll_rst_c3", pll_rst, 1);
        goto(4);  chk("mr_pll_rst_c4", pll_rst, 0);
        goto(12); chk("mr_rst_out_c12", rst_out, 3'b111);
        goto(13); chk("mr_rst_out_c13", rst_out, 3'b110);
        goto(17); chk("mr_locked_c17", locked, 0);
        goto(18); chk("mr_locked_c18", locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
